// File: rtl/tbeb_dec.sv
// 8b10b symbol decoder: byte/K decode, running-disparity tracking and error flags.
// Optional word-sync FSM compiled in with TBEB_SYNC_FSM_EN; otherwise sync is tied high.
`timescale 1ns/1ps
module tbeb_dec (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [9:0] tb,
    output logic       out_valid,
    output logic [7:0] eb,
    output logic       k,
    output logic       rd,
    output logic       code_err,
    output logic       disp_err,
    output logic       sync
);
    localparam int unsigned W6 = 6;
    localparam int unsigned W4 = 4;

    logic [W6-1:0] s6;
    logic [W4-1:0] s4, f4;
    logic [2:0]    w6, w4, y3;
    logic [4:0]    x5;
    logic          k28, bad6, bad4;
    logic          alt4, p7, kneg, kpos, bad_alt, bad_p7;
    logic          ex6_def, ex6_val, rq4_def, rq4_val, combo_err;
    logic          fp6, fn6, fp4, fn4, rd_mid, de6, de4;
    logic          code_err_c, disp_err_c, k_c, rd_c;
    logic [7:0]    eb_c;

    assign s6 = tb[9:4];
    assign s4 = tb[3:0];
    assign w6 = 3'(s6[0]) + 3'(s6[1]) + 3'(s6[2]) + 3'(s6[3]) + 3'(s6[4]) + 3'(s6[5]);
    assign w4 = 3'(s4[0]) + 3'(s4[1]) + 3'(s4[2]) + 3'(s4[3]);

    // 5b/6b table, both disparity forms map to the same EDCBA
    always_comb begin
        x5   = 5'd0;
        k28  = 1'b0;
        bad6 = 1'b0;
        case (s6)
            6'b100111, 6'b011000: x5 = 5'd0;
            6'b011101, 6'b100010: x5 = 5'd1;
            6'b101101, 6'b010010: x5 = 5'd2;
            6'b110001:            x5 = 5'd3;
            6'b110101, 6'b001010: x5 = 5'd4;
            6'b101001:            x5 = 5'd5;
            6'b011001:            x5 = 5'd6;
            6'b111000, 6'b000111: x5 = 5'd7;
            6'b111001, 6'b000110: x5 = 5'd8;
            6'b100101:            x5 = 5'd9;
            6'b010101:            x5 = 5'd10;
            6'b110100:            x5 = 5'd11;
            6'b001101:            x5 = 5'd12;
            6'b101100:            x5 = 5'd13;
            6'b011100:            x5 = 5'd14;
            6'b010111, 6'b101000: x5 = 5'd15;
            6'b011011, 6'b100100: x5 = 5'd16;
            6'b100011:            x5 = 5'd17;
            6'b010011:            x5 = 5'd18;
            6'b110010:            x5 = 5'd19;
            6'b001011:            x5 = 5'd20;
            6'b101010:            x5 = 5'd21;
            6'b011010:            x5 = 5'd22;
            6'b111010, 6'b000101: x5 = 5'd23;
            6'b110011, 6'b001100: x5 = 5'd24;
            6'b100110:            x5 = 5'd25;
            6'b010110:            x5 = 5'd26;
            6'b110110, 6'b001001: x5 = 5'd27;
            6'b001110:            x5 = 5'd28;
            6'b001111, 6'b110000: begin x5 = 5'd28; k28 = 1'b1; end
            6'b101110, 6'b010001: x5 = 5'd29;
            6'b011110, 6'b100001: x5 = 5'd30;
            6'b101011, 6'b010100: x5 = 5'd31;
            default:              bad6 = 1'b1;
        endcase
    end

    // K28 in its RD+ form carries an inverted 4b block
    assign f4 = (s6 == 6'b110000) ? ~s4 : s4;

    always_comb begin
        y3   = 3'd0;
        bad4 = 1'b0;
        case (f4)
            4'b1011, 4'b0100:                   y3 = 3'd0;
            4'b1001:                            y3 = 3'd1;
            4'b0101:                            y3 = 3'd2;
            4'b1100, 4'b0011:                   y3 = 3'd3;
            4'b1101, 4'b0010:                   y3 = 3'd4;
            4'b1010:                            y3 = 3'd5;
            4'b0110:                            y3 = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: y3 = 3'd7;
            default:                            bad4 = 1'b1;
        endcase
    end

    // A7 only where P7 would build a run of five, or on the K.x.7 codes
    assign alt4 = (s4 == 4'b0111) || (s4 == 4'b1000);
    assign p7   = (s4 == 4'b1110) || (s4 == 4'b0001);
    assign kneg = (s6 == 6'b000101) || (s6 == 6'b001001) || (s6 == 6'b010001) ||
                  (s6 == 6'b100001) || (s6 == 6'b110000);
    assign kpos = (s6 == 6'b111010) || (s6 == 6'b110110) || (s6 == 6'b101110) ||
                  (s6 == 6'b011110) || (s6 == 6'b001111);
    assign bad_alt = alt4 && !((s4 == 4'b0111 && (s6[1:0] == 2'b11 || kneg)) ||
                               (s4 == 4'b1000 && (s6[1:0] == 2'b00 || kpos)));
    assign bad_p7  = p7 && (k28 || (s4 == 4'b1110 && s6[1:0] == 2'b11) ||
                                   (s4 == 4'b0001 && s6[1:0] == 2'b00));

    assign fp6 = (s6 == 6'b000111);
    assign fn6 = (s6 == 6'b111000);
    assign fp4 = (s4 == 4'b0011);
    assign fn4 = (s4 == 4'b1100);

    // Sub-block pairs that no entry disparity can produce
    assign ex6_def   = (w6 != 3'd3) || fp6 || fn6;
    assign ex6_val   = (w6 > 3'd3) || fp6;
    assign rq4_def   = (w4 != 3'd2) || fp4 || fn4;
    assign rq4_val   = (w4 < 3'd2) || fp4;
    assign combo_err = ex6_def && rq4_def && (ex6_val != rq4_val);

    assign code_err_c = bad6 | bad4 | combo_err | bad_alt | bad_p7;
    assign k_c        = !code_err_c && (k28 || (alt4 && (kneg || kpos)));
    assign eb_c       = code_err_c ? 8'h00 : {y3, x5};

    // Running disparity, 6b block then 4b block
    assign de6    = (w6 == 3'd4 && rd) || (w6 == 3'd2 && !rd) || (fp6 && !rd) || (fn6 && rd);
    assign rd_mid = ((w6 > 3'd3) || fp6) ? 1'b1 : ((w6 < 3'd3) || fn6) ? 1'b0 : rd;
    assign de4    = (w4 == 3'd3 && rd_mid) || (w4 == 3'd1 && !rd_mid) ||
                    (fp4 && !rd_mid) || (fn4 && rd_mid);
    assign rd_c   = ((w4 > 3'd2) || fp4) ? 1'b1 : ((w4 < 3'd2) || fn4) ? 1'b0 : rd_mid;
    assign disp_err_c = de6 | de4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            eb        <= 8'h00;
            k         <= 1'b0;
            rd        <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                eb       <= eb_c;
                k        <= k_c;
                rd       <= rd_c;
                code_err <= code_err_c;
                disp_err <= disp_err_c;
            end
        end
    end

`ifdef TBEB_SYNC_FSM_EN
    typedef enum logic [1:0] {ST_LOS, ST_ACQ, ST_SYNC} sync_state_t;

    sync_state_t state;
    logic [2:0]  err_cnt;
    logic [3:0]  good_cnt;
    logic        err_c, comma_c;

    assign err_c   = code_err_c | disp_err_c;
    assign comma_c = k28 && !code_err_c && (y3 == 3'd1 || y3 == 3'd5 || y3 == 3'd7);

    // sync is registered from the state reached by the same symbol
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_LOS;
            err_cnt  <= 3'd0;
            good_cnt <= 4'd0;
            sync     <= 1'b0;
        end else if (in_valid) begin
            case (state)
                ST_LOS: begin
                    sync <= 1'b0;
                    if (!err_c && comma_c) state <= ST_ACQ;
                end
                ST_ACQ: begin
                    sync <= 1'b0;
                    if (err_c) begin
                        state <= ST_LOS;
                    end else if (comma_c) begin
                        state    <= ST_SYNC;
                        err_cnt  <= 3'd0;
                        good_cnt <= 4'd0;
                        sync     <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    sync <= 1'b1;
                    if (err_c) begin
                        good_cnt <= 4'd0;
                        if (err_cnt == 3'd3) begin
                            state   <= ST_LOS;
                            err_cnt <= 3'd0;
                            sync    <= 1'b0;
                        end else begin
                            err_cnt <= err_cnt + 3'd1;
                        end
                    end else if (good_cnt == 4'd15) begin
                        good_cnt <= 4'd0;
                        err_cnt  <= 3'd0;
                    end else begin
                        good_cnt <= good_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_LOS;
                    sync  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign sync = 1'b1;
`endif

endmodule

// File: tb/tb_tbeb_dec.sv
// Scoreboard bench for tbeb_dec: directed 10b symbols, expected bytes/flags queued at issue time.
`timescale 1ns/1ps
module tb_tbeb_dec;
    typedef struct packed {
        logic [7:0] eb;
        logic       k;
        logic       rd;
        logic       ce;
        logic       de;
        logic       sy;
    } exp_t;

`ifdef TBEB_SYNC_FSM_EN
    localparam bit FSM_EN = 1'b1;
`else
    localparam bit FSM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [9:0] tb;
    logic       out_valid, k, rd, code_err, disp_err, sync;
    logic [7:0] eb;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t expq[$];
    exp_t last;
    exp_t rst_val;

    tbeb_dec dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .tb(tb),
        .out_valid(out_valid), .eb(eb), .k(k), .rd(rd),
        .code_err(code_err), .disp_err(disp_err), .sync(sync)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] b, input logic kk, input logic r,
                                input logic c, input logic d, input logic s_fsm);
        exp_t e;
        e.eb = b; e.k = kk; e.rd = r; e.ce = c; e.de = d;
        e.sy = FSM_EN ? s_fsm : 1'b1;
        return e;
    endfunction

    function automatic exp_t act_now();
        exp_t a;
        a.eb = eb; a.k = k; a.rd = rd; a.ce = code_err; a.de = disp_err; a.sy = sync;
        return a;
    endfunction

    // Monitor: pop on every out_valid, otherwise outputs must hold
    always @(negedge clk) begin
        exp_t e, a;
        if (!reset) begin
            last = rst_val;
        end else if (out_valid) begin
            compared++;
            a = act_now();
            if (expq.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_out: eb=%h k=%b rd=%b ce=%b de=%b sync=%b with empty queue",
                         a.eb, a.k, a.rd, a.ce, a.de, a.sy);
            end else begin
                e = expq.pop_front();
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL decode @%0t: got eb=%h k=%b rd=%b ce=%b de=%b sync=%b, want eb=%h k=%b rd=%b ce=%b de=%b sync=%b",
                             $time, a.eb, a.k, a.rd, a.ce, a.de, a.sy, e.eb, e.k, e.rd, e.ce, e.de, e.sy);
                end
                last = e;
            end
        end else begin
            compared++;
            a = act_now();
            if (a !== last) begin
                mismatched++;
                $display("FAIL hold @%0t: got eb=%h k=%b rd=%b ce=%b de=%b sync=%b, want eb=%h k=%b rd=%b ce=%b de=%b sync=%b",
                         $time, a.eb, a.k, a.rd, a.ce, a.de, a.sy, last.eb, last.k, last.rd, last.ce, last.de, last.sy);
            end
        end
    end

    task automatic send(input logic [9:0] sym, input exp_t e);
        @(posedge clk);
        #1;
        tb = sym;
        in_valid = 1'b1;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tb = 10'h000;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
        #1;
        compared++;
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d outputs never appeared, want 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic check_rst(input string name);
        compared++;
        if ({out_valid, act_now()} !== {1'b0, rst_val}) begin
            mismatched++;
            $display("FAIL %s: got ov=%b eb=%h k=%b rd=%b ce=%b de=%b sync=%b, want ov=0 eb=00 k=0 rd=0 ce=0 de=0 sync=%b",
                     name, out_valid, eb, k, rd, code_err, disp_err, sync, rst_val.sy);
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        tb = 10'h000;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    logic [9:0] vsym [15];
    exp_t       vexp [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_val = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        last = rst_val;
        reset = 1'b0;
        in_valid = 1'b0;
        tb = 10'h000;

        vsym = '{10'h0FA, 10'h18B, 10'h2AA, 10'h313, 10'h231, 10'h237, 10'h307, 10'h057,
                 10'h074, 10'h18B, 10'h38B, 10'h000, 10'h27B, 10'h23E, 10'h306};
        vexp[0]  = mk(8'hBC, 1, 1, 0, 0, 0);
        vexp[1]  = mk(8'h00, 0, 1, 0, 0, 0);
        vexp[2]  = mk(8'hB5, 0, 1, 0, 0, 0);
        vexp[3]  = mk(8'h63, 0, 1, 0, 0, 0);
        vexp[4]  = mk(8'hF1, 0, 0, 0, 0, 0);
        vexp[5]  = mk(8'hF1, 0, 1, 0, 0, 0);
        vexp[6]  = mk(8'hFC, 1, 1, 0, 0, 1);
        vexp[7]  = mk(8'hF7, 1, 1, 0, 0, 1);
        vexp[8]  = mk(8'h07, 0, 0, 0, 0, 1);
        vexp[9]  = mk(8'h00, 0, 1, 0, 1, 1);
        vexp[10] = mk(8'h07, 0, 1, 0, 1, 1);
        vexp[11] = mk(8'h00, 0, 0, 1, 0, 1);
        vexp[12] = mk(8'h00, 0, 1, 1, 1, 0);
        vexp[13] = mk(8'h00, 0, 1, 1, 1, 0);
        vexp[14] = mk(8'h3C, 1, 0, 0, 0, 0);

        apply_reset();
        check_rst("reset_init");

        for (int i = 0; i < 15; i++) begin
            if (i == 3) idle(2);
            send(vsym[i], vexp[i]);
        end

        // Mid-stream reset with a symbol in flight
        send(10'h2AA, mk(8'hB5, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        tb = 10'h0FA;
        in_valid = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check_rst("reset_async");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_rst("reset_held");
        #2 reset = 1'b1;
        drain();

        // First symbol after reset judged against RD-
        send(10'h305, mk(8'hBC, 1, 0, 0, 1, 0));
        send(10'h000, mk(8'h00, 0, 0, 1, 0, 0));
        idle(3);
        drain();

`ifdef TBEB_SYNC_FSM_EN
        apply_reset();
        check_rst("reset_fsm");
        send(10'h0FA, mk(8'hBC, 1, 1, 0, 0, 0));
        send(10'h305, mk(8'hBC, 1, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) send(10'h000, mk(8'h00, 0, 0, 1, 0, (i < 3)));

        // 16 good symbols clear the error count
        send(10'h0FA, mk(8'hBC, 1, 1, 0, 0, 0));
        send(10'h305, mk(8'hBC, 1, 0, 0, 0, 1));
        send(10'h000, mk(8'h00, 0, 0, 1, 0, 1));
        for (int i = 0; i < 16; i++) send(10'h2AA, mk(8'hB5, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) send(10'h000, mk(8'h00, 0, 0, 1, 0, 1));
        send(10'h000, mk(8'h00, 0, 0, 1, 0, 0));

        // Runs of 15 good never clear the count
        send(10'h0FA, mk(8'hBC, 1, 1, 0, 0, 0));
        send(10'h305, mk(8'hBC, 1, 0, 0, 0, 1));
        for (int r = 0; r < 3; r++) begin
            send(10'h000, mk(8'h00, 0, 0, 1, 0, 1));
            if (r < 2)
                for (int i = 0; i < 15; i++) send(10'h2AA, mk(8'hB5, 0, 0, 0, 0, 1));
        end
        send(10'h000, mk(8'h00, 0, 0, 1, 0, 0));
        idle(2);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
